buffet_regfile: RTL and testbench

Parametrised successor buffet. Internal register-file storage of any depth, power of two not required. Fill, Read, Update and Shrink are all handled in one block, with per-entry RAW scoreboarding and batched credit return. Intended as the drop-in storage/control core for small buffets (DEPTH ≤ 64), where an SRAM macro plus separate control is overkill.

---
 rtl/buffet_regfile_if.sv | 40 ++++
 rtl/buffet_regfile.sv | 109 ++++++++++
 tb/tb_buffet_regfile.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/buffet_regfile_if.sv
// Bundle of fill, read, update and credit channels between a buffet and its producer/consumer.
interface buffet_regfile_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_data_valid;
  logic                  push_data_ready;
  logic [IDX_WIDTH-1:0]  read_idx;
  logic                  read_idx_valid;
  logic                  read_idx_ready;
  logic                  read_will_update;
  logic                  is_shrink;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_data_valid;
  logic                  read_data_ready;
  logic [IDX_WIDTH-1:0]  update_idx;
  logic [DATA_WIDTH-1:0] update_data;
  logic                  update_valid;
  logic                  update_ready;
  logic                  update_err;
  logic [IDX_WIDTH:0]    credit_out;
  logic                  credit_valid;
  logic                  credit_ready;
  logic [IDX_WIDTH:0]    occupancy;

  modport slave (
    input  push_data, push_data_valid, read_idx, read_idx_valid, read_will_update,
           is_shrink, read_data_ready, update_idx, update_data, update_valid, credit_ready,
    output push_data_ready, read_idx_ready, read_data, read_data_valid, update_ready,
           update_err, credit_out, credit_valid, occupancy
  );

  modport master (
    output push_data, push_data_valid, read_idx, read_idx_valid, read_will_update,
           is_shrink, read_data_ready, update_idx, update_data, update_valid, credit_ready,
    input  push_data_ready, read_idx_ready, read_data, read_data_valid, update_ready,
           update_err, credit_out, credit_valid, occupancy
  );
endinterface

// File: rtl/buffet_regfile.sv
// Register-file buffet: circular storage with fill/read/update/shrink, per-entry
// read-after-write pending bits and batched credit return.
module buffet_regfile #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IDX_WIDTH    = 4,
  parameter int unsigned DEPTH        = 12,
  parameter int unsigned CREDIT_BATCH = 1
) (
  input logic              clk,
  input logic              nreset_i,
  buffet_regfile_if.slave  bus
);

  localparam int unsigned CW = IDX_WIDTH + 1;
  localparam int unsigned SW = IDX_WIDTH + 2;

  typedef logic [IDX_WIDTH-1:0] idx_t;
  typedef logic [CW-1:0]        cnt_t;

  // Relative-to-physical slot; one compare-and-subtract suffices since head < DEPTH.
  function automatic idx_t phys(input idx_t h, input cnt_t i);
    logic [SW-1:0] s;
    s = SW'(h) + SW'(i);
    if (s >= SW'(DEPTH)) s = s - SW'(DEPTH);
    return s[IDX_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      pending, pending_nxt;
  idx_t                  head;
  cnt_t                  count, pending_cnt, credit_acc;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  upd_err, upd_rdy;

  logic fill, out_free, read_ok, shrink_ok, read_fire, shrink_fire;
  logic upd_hit, credit_vld, credit_fire, set_pend;
  idx_t fill_slot, rd_slot, upd_slot;
  cnt_t shrink_sz;

  always_comb begin
    fill        = bus.push_data_valid && (count < CW'(DEPTH));
    fill_slot   = phys(head, count);
    rd_slot     = phys(head, CW'(bus.read_idx));
    upd_slot    = phys(head, CW'(bus.update_idx));
    out_free    = !rd_valid || bus.read_data_ready;
    read_ok     = !bus.is_shrink && (CW'(bus.read_idx) < count) && !pending[rd_slot] && out_free;
    shrink_ok   = bus.is_shrink && (CW'(bus.read_idx) <= count) && (pending_cnt == '0);
    read_fire   = bus.read_idx_valid && read_ok;
    shrink_fire = bus.read_idx_valid && shrink_ok;
    shrink_sz   = shrink_fire ? CW'(bus.read_idx) : '0;
    upd_hit     = bus.update_valid && (CW'(bus.update_idx) < CW'(DEPTH)) && pending[upd_slot];
    credit_vld  = credit_acc >= CW'(CREDIT_BATCH);
    credit_fire = credit_vld && bus.credit_ready;
    set_pend    = read_fire && bus.read_will_update;
  end

  // An entry being read is never pending, so set and clear never hit the same bit.
  always_comb begin
    pending_nxt = pending;
    if (upd_hit)  pending_nxt[upd_slot] = 1'b0;
    if (set_pend) pending_nxt[rd_slot]  = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      head        <= '0;
      count       <= '0;
      pending     <= '0;
      pending_cnt <= '0;
      credit_acc  <= CW'(DEPTH);
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      upd_err     <= 1'b0;
      upd_rdy     <= 1'b0;
    end else begin
      upd_rdy     <= 1'b1;
      upd_err     <= bus.update_valid && !upd_hit;
      count       <= count + CW'(fill) - shrink_sz;
      credit_acc  <= credit_acc - (credit_fire ? credit_acc : '0) + shrink_sz;
      pending     <= pending_nxt;
      pending_cnt <= pending_cnt + CW'(set_pend) - CW'(upd_hit);
      if (shrink_fire) head <= phys(head, shrink_sz);
      if (read_fire) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_slot];
      end else if (bus.read_data_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Storage is not reset; fill slot is never pending so the two writes never collide.
  always_ff @(posedge clk) begin
    if (fill)    mem[fill_slot] <= bus.push_data;
    if (upd_hit) mem[upd_slot]  <= bus.update_data;
  end

  assign bus.push_data_ready = count < CW'(DEPTH);
  assign bus.read_idx_ready  = read_ok || shrink_ok;
  assign bus.read_data       = rd_data;
  assign bus.read_data_valid = rd_valid;
  assign bus.update_ready    = upd_rdy;
  assign bus.update_err      = upd_err;
  assign bus.credit_out      = credit_acc;
  assign bus.credit_valid    = credit_vld;
  assign bus.occupancy       = count;

endmodule

// File: tb/tb_buffet_regfile.sv
// Directed bench for buffet_regfile: fill, read, RAW stall, update error, wrap,
// shrink blocking, output back-pressure and asynchronous reset.
module tb_buffet_regfile;

  logic clk = 1'b0;
  logic nreset_i;
  int   checks = 0;
  int   errors = 0;

  buffet_regfile_if #(.DATA_WIDTH(32), .IDX_WIDTH(4)) bus ();

  buffet_regfile #(.DATA_WIDTH(32), .IDX_WIDTH(4), .DEPTH(12), .CREDIT_BATCH(1)) dut (
    .clk      (clk),
    .nreset_i (nreset_i),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset_i             = 1'b0;
    bus.push_data        = '0;
    bus.push_data_valid  = 1'b0;
    bus.read_idx         = '0;
    bus.read_idx_valid   = 1'b0;
    bus.read_will_update = 1'b0;
    bus.is_shrink        = 1'b0;
    bus.read_data_ready  = 1'b1;
    bus.update_idx       = '0;
    bus.update_data      = '0;
    bus.update_valid     = 1'b0;
    bus.credit_ready     = 1'b1;

    // Reset values
    tick();
    #1;
    chk("rst_update_ready", 64'(bus.update_ready), 0);
    chk("rst_occupancy", 64'(bus.occupancy), 0);
    chk("rst_rd_valid", 64'(bus.read_data_valid), 0);
    tick();
    nreset_i = 1'b1;
    #1;
    chk("init_credit_valid", 64'(bus.credit_valid), 1);
    chk("init_credit_out", 64'(bus.credit_out), 12);
    tick();
    chk("credit_drained_valid", 64'(bus.credit_valid), 0);
    chk("credit_drained_out", 64'(bus.credit_out), 0);
    chk("update_ready_up", 64'(bus.update_ready), 1);

    // Fill 12 words
    for (int i = 0; i < 12; i++) begin
      bus.push_data       = 32'hA0 + 32'(i);
      bus.push_data_valid = 1'b1;
      tick();
    end
    bus.push_data_valid = 1'b0;
    #1;
    chk("full_occupancy", 64'(bus.occupancy), 12);
    chk("full_push_ready", 64'(bus.push_data_ready), 0);

    // Plain read idx 3
    bus.read_idx = 4'd3;
    bus.read_idx_valid = 1'b1;
    #1;
    chk("rd3_ready", 64'(bus.read_idx_ready), 1);
    tick();
    bus.read_idx_valid = 1'b0;
    chk("rd3_valid", 64'(bus.read_data_valid), 1);
    chk("rd3_data", 64'(bus.read_data), 64'hA3);

    // Out-of-range read idx 12 stays blocked
    bus.read_idx = 4'd12;
    bus.read_idx_valid = 1'b1;
    #1;
    chk("rd12_blocked", 64'(bus.read_idx_ready), 0);
    tick();
    chk("rd12_still_blocked", 64'(bus.read_idx_ready), 0);

    // Read idx 2 with will_update, then RAW stall on idx 2
    bus.read_idx = 4'd2;
    bus.read_will_update = 1'b1;
    #1;
    chk("rd2wu_ready", 64'(bus.read_idx_ready), 1);
    tick();
    bus.read_will_update = 1'b0;
    chk("rd2wu_data", 64'(bus.read_data), 64'hA2);
    chk("rd2_stall", 64'(bus.read_idx_ready), 0);
    tick();
    chk("rd2_stall2", 64'(bus.read_idx_ready), 0);
    bus.update_idx   = 4'd2;
    bus.update_data  = 32'h55;
    bus.update_valid = 1'b1;
    #1;
    chk("rd2_blocked_same_cycle", 64'(bus.read_idx_ready), 0);
    tick();
    bus.update_valid = 1'b0;
    #1;
    chk("rd2_unblocked", 64'(bus.read_idx_ready), 1);
    chk("upd2_no_err", 64'(bus.update_err), 0);
    tick();
    bus.read_idx_valid = 1'b0;
    chk("rd2_updated_valid", 64'(bus.read_data_valid), 1);
    chk("rd2_updated_data", 64'(bus.read_data), 64'h55);

    // Update without pending bit
    bus.update_idx   = 4'd5;
    bus.update_data  = 32'h77;
    bus.update_valid = 1'b1;
    tick();
    bus.update_valid = 1'b0;
    chk("upd5_err_pulse", 64'(bus.update_err), 1);
    bus.read_idx = 4'd5;
    bus.read_idx_valid = 1'b1;
    tick();
    bus.read_idx_valid = 1'b0;
    chk("upd5_err_cleared", 64'(bus.update_err), 0);
    chk("rd5_old_data", 64'(bus.read_data), 64'hA5);

    // Shrink 10, then wrap-around fill
    bus.read_idx = 4'd10;
    bus.is_shrink = 1'b1;
    bus.read_idx_valid = 1'b1;
    #1;
    chk("shrink10_ready", 64'(bus.read_idx_ready), 1);
    tick();
    bus.read_idx_valid = 1'b0;
    bus.is_shrink = 1'b0;
    chk("shrink10_credit_valid", 64'(bus.credit_valid), 1);
    chk("shrink10_credit_out", 64'(bus.credit_out), 10);
    chk("shrink10_occupancy", 64'(bus.occupancy), 2);
    for (int i = 0; i < 8; i++) begin
      bus.push_data       = 32'hB0 + 32'(i);
      bus.push_data_valid = 1'b1;
      tick();
    end
    bus.push_data_valid = 1'b0;
    chk("wrap_occupancy", 64'(bus.occupancy), 10);
    bus.read_idx = 4'd2;
    bus.read_idx_valid = 1'b1;
    tick();
    bus.read_idx_valid = 1'b0;
    chk("wrap_rd2_data", 64'(bus.read_data), 64'hB0);

    // Shrink blocked while an update is pending
    bus.read_idx = 4'd1;
    bus.read_will_update = 1'b1;
    bus.read_idx_valid = 1'b1;
    tick();
    bus.read_will_update = 1'b0;
    chk("rd1wu_data", 64'(bus.read_data), 64'hAB);
    bus.is_shrink = 1'b1;
    #1;
    chk("shrink_blocked", 64'(bus.read_idx_ready), 0);
    tick();
    chk("shrink_blocked2", 64'(bus.read_idx_ready), 0);
    bus.update_idx   = 4'd1;
    bus.update_data  = 32'h99;
    bus.update_valid = 1'b1;
    tick();
    bus.update_valid = 1'b0;
    #1;
    chk("shrink_unblocked", 64'(bus.read_idx_ready), 1);
    tick();
    bus.read_idx_valid = 1'b0;
    bus.is_shrink = 1'b0;
    chk("shrink1_occupancy", 64'(bus.occupancy), 9);
    chk("shrink1_credit_out", 64'(bus.credit_out), 1);

    // Output register held under back-pressure
    bus.read_data_ready = 1'b0;
    bus.read_idx = 4'd0;
    bus.read_idx_valid = 1'b1;
    tick();
    chk("hold_rd0_data", 64'(bus.read_data), 64'h99);
    bus.read_idx = 4'd1;
    #1;
    chk("hold_next_stalled", 64'(bus.read_idx_ready), 0);
    tick();
    chk("hold_data_stable", 64'(bus.read_data), 64'h99);
    chk("hold_valid_stable", 64'(bus.read_data_valid), 1);
    bus.read_data_ready = 1'b1;
    #1;
    chk("hold_released", 64'(bus.read_idx_ready), 1);
    tick();
    bus.read_idx_valid = 1'b0;
    chk("hold_rd1_data", 64'(bus.read_data), 64'hB0);

    // Asynchronous reset in the middle of a burst with a held response
    bus.read_data_ready = 1'b0;
    bus.push_data = 32'hC0;
    bus.push_data_valid = 1'b1;
    tick();
    chk("pre_rst_held", 64'(bus.read_data_valid), 1);
    #2;
    nreset_i = 1'b0;
    #1;
    chk("async_rst_rd_valid", 64'(bus.read_data_valid), 0);
    chk("async_rst_rd_data", 64'(bus.read_data), 0);
    chk("async_rst_occupancy", 64'(bus.occupancy), 0);
    chk("async_rst_update_ready", 64'(bus.update_ready), 0);
    chk("async_rst_credit_out", 64'(bus.credit_out), 12);
    chk("async_rst_push_ready", 64'(bus.push_data_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
